// File: rtl/rv32i_pkg.sv
// Shared RV32I types for the MEM-stage load/store path: FSM states, funct3 codes, access sizes.
package rv32i_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Undefined encodings (and the unsigned codes on stores) fall back to a full word.
    function automatic acc_size_e access_size(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B:    return SZ_B;
            F3_H:    return SZ_H;
            F3_BU:   return is_store ? SZ_W : SZ_B;
            F3_HU:   return is_store ? SZ_W : SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data aligner: picks the addressed byte/half and sign- or zero-extends it.
module load_formatter
    import rv32i_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_result = i_rdata;
        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_result = {24'h0, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_HU:   o_result = {16'h0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I MEM-stage load/store unit: valid/ready data-memory master with pipeline stall.
// Define MEM_LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating.
module mem_stage_lsu
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALU_MEM,
    input  logic [31:0] RS2_MEM,
    input  logic [31:0] INST_MEM,
    input  logic        MemRd_MEM,
    input  logic        MemWr_MEM,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] data_mem_out,
    output logic        stall_mem,
    output logic        bus_err,
    output logic        misalign_exc
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);
    localparam bit         TimeoutEn  = (TIMEOUT_CYCLES != 0);

    lsu_state_e  r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [31:0] r_addr, r_wdata, r_data_out, w_data_nxt;
    logic [3:0]  r_be;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        r_bus_err, w_bus_err_nxt;
    logic        r_misalign, w_misalign_nxt;

    logic        w_access, w_issue, w_misalign, w_timeout, w_stall;
    logic [2:0]  w_f3;
    logic [1:0]  w_off;
    acc_size_e   w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_fmt;

    logic        unused_inst;
    assign unused_inst = ^{INST_MEM[31:15], INST_MEM[11:0]};

    assign w_access = MemRd_MEM | MemWr_MEM;
    assign w_f3     = INST_MEM[14:12];
    assign w_off    = ALU_MEM[1:0];
    assign w_size   = access_size(w_f3, MemWr_MEM);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == SZ_H) && w_off[0]) || ((w_size == SZ_W) && (w_off != 2'd0));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_be    = 4'hF;
        w_wdata = RS2_MEM;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{RS2_MEM[7:0]}};
            end
            SZ_H: begin
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{RS2_MEM[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = RS2_MEM;
            end
        endcase
    end

    load_formatter u_load_formatter (
        .i_rdata  (dmem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_result (w_fmt)
    );

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = TimeoutEn && (w_cnt_inc == TimeoutCnt);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_data_nxt     = r_data_out;
        w_bus_err_nxt  = 1'b0;
        w_misalign_nxt = 1'b0;
        w_issue        = 1'b0;
        w_stall        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_stall = 1'b1;
                    if (w_misalign) begin
                        w_misalign_nxt = 1'b1;
                        w_data_nxt     = 32'h0;
                        w_state_nxt    = DONE;
                    end else begin
                        w_issue     = 1'b1;
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (dmem_req_ready) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = r_we ? DONE : WAIT;
                end else if (w_timeout) begin
                    w_bus_err_nxt = 1'b1;
                    w_data_nxt    = 32'h0;
                    w_state_nxt   = DONE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (dmem_rsp_valid) begin
                    w_data_nxt  = w_fmt;
                    w_state_nxt = DONE;
                end else if (w_timeout) begin
                    w_bus_err_nxt = 1'b1;
                    w_data_nxt    = 32'h0;
                    w_state_nxt   = DONE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_data_out <= 32'h0;
            r_bus_err  <= 1'b0;
            r_misalign <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_be       <= 4'h0;
            r_we       <= 1'b0;
            r_f3       <= 3'b000;
            r_off      <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data_out <= w_data_nxt;
            r_bus_err  <= w_bus_err_nxt;
            r_misalign <= w_misalign_nxt;
            // Request fields are frozen here so the bus sees them stable until ready.
            if (w_issue) begin
                r_addr  <= {ALU_MEM[31:2], 2'b00};
                r_wdata <= w_wdata;
                r_be    <= w_be;
                r_we    <= MemWr_MEM;
                r_f3    <= w_f3;
                r_off   <= w_off;
            end
        end
    end

    assign dmem_req_valid = (r_state == REQ);
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_wdata     = r_wdata;
    assign dmem_be        = r_be;
    assign data_mem_out   = r_data_out;
    assign stall_mem      = w_stall;
    assign bus_err        = r_bus_err;
    assign misalign_exc   = r_misalign;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (TIMEOUT_CYCLES=4); honours MEM_LSU_MISALIGN_TRAP_EN.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALU_MEM, RS2_MEM, INST_MEM;
    logic        MemRd_MEM, MemWr_MEM;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata, data_mem_out;
    logic        stall_mem, bus_err, misalign_exc;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ALU_MEM        (ALU_MEM),
        .RS2_MEM        (RS2_MEM),
        .INST_MEM       (INST_MEM),
        .MemRd_MEM      (MemRd_MEM),
        .MemWr_MEM      (MemWr_MEM),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .data_mem_out   (data_mem_out),
        .stall_mem      (stall_mem),
        .bus_err        (bus_err),
        .misalign_exc   (misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an access in IDLE; the next negedge is the first REQ (or DONE) cycle.
    task automatic start(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [2:0] f3);
        @(negedge clk);
        MemRd_MEM = rd;
        MemWr_MEM = wr;
        ALU_MEM   = addr;
        RS2_MEM   = rs2;
        INST_MEM  = {17'h0, f3, 5'h0, (wr ? 7'b0100011 : 7'b0000011)};
        #1;
        check({tag, "_stall_idle"}, 32'(stall_mem), 32'd1);
        check({tag, "_valid_idle"}, 32'(dmem_req_valid), 32'd0);
    endtask

    task automatic store_txn(input string tag, input logic [31:0] addr, input logic [31:0] rs2,
                             input logic [2:0] f3, input int ready_delay,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        start(tag, 1'b0, 1'b1, addr, rs2, f3);
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk); #1;
            check({tag, "_valid_wait"}, 32'(dmem_req_valid), 32'd1);
            check({tag, "_stall_wait"}, 32'(stall_mem), 32'd1);
        end
        @(negedge clk);
        dmem_req_ready = 1'b1;
        #1;
        check({tag, "_valid"}, 32'(dmem_req_valid), 32'd1);
        check({tag, "_we"}, 32'(dmem_we), 32'd1);
        check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
        check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        check({tag, "_stall_req"}, 32'(stall_mem), 32'd1);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        MemWr_MEM = 1'b0;
        #1;
        check({tag, "_stall_done"}, 32'(stall_mem), 32'd0);
        check({tag, "_valid_done"}, 32'(dmem_req_valid), 32'd0);
    endtask

    task automatic load_txn(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
        start(tag, 1'b1, 1'b0, addr, 32'h0, f3);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        #1;
        check({tag, "_valid"}, 32'(dmem_req_valid), 32'd1);
        check({tag, "_we"}, 32'(dmem_we), 32'd0);
        check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        check({tag, "_valid_rsp"}, 32'(dmem_req_valid), 32'd0);
        check({tag, "_stall_rsp"}, 32'(stall_mem), 32'd1);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rdata;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h5A5A_5A5A;
        MemRd_MEM      = 1'b0;
        #1;
        check({tag, "_stall_done"}, 32'(stall_mem), 32'd0);
        check({tag, "_data"}, data_mem_out, exp_data);
        @(negedge clk); #1;
        check({tag, "_data_hold"}, data_mem_out, exp_data);
    endtask

    initial begin
        rst_n          = 1'b0;
        ALU_MEM        = 32'h0;
        RS2_MEM        = 32'h0;
        INST_MEM       = 32'h0;
        MemRd_MEM      = 1'b0;
        MemWr_MEM      = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;

        @(negedge clk); #1;
        check("rst_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_data", data_mem_out, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_misalign", 32'(misalign_exc), 32'd0);
        check("rst_stall", 32'(stall_mem), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("idle_stall", 32'(stall_mem), 32'd0);

        // Stores: ready on second REQ cycle for SW, immediately otherwise.
        store_txn("sw", 32'h100, 32'hDEAD_BEEF, 3'b010, 1, 4'hF, 32'hDEAD_BEEF);
        store_txn("sh", 32'h22, 32'h1234_ABCD, 3'b001, 0, 4'b1100, 32'hABCD_ABCD);
        store_txn("sb", 32'h101, 32'h0000_0055, 3'b000, 0, 4'b0010, 32'h5555_5555);

        // Loads.
        load_txn("lb", 32'h103, 3'b000, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
        load_txn("lbu", 32'h103, 3'b100, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
        load_txn("lb_pos", 32'h101, 3'b000, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
        load_txn("lhu", 32'h22, 3'b101, 32'hABCD_0000, 4'b1100, 32'h0000_ABCD);
        load_txn("lh", 32'h22, 3'b001, 32'hABCD_0000, 4'b1100, 32'hFFFF_ABCD);
        load_txn("lw", 32'h200, 3'b010, 32'h1357_9BDF, 4'hF, 32'h1357_9BDF);
        load_txn("f3_undef", 32'h204, 3'b011, 32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D);

        // Timeout: ready never comes; bus_err in the DONE cycle after 4 REQ cycles.
        start("to", 1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("to_valid", 32'(dmem_req_valid), 32'd1);
            check("to_bus_err_early", 32'(bus_err), 32'd0);
        end
        @(negedge clk);
        MemRd_MEM = 1'b0;
        #1;
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_valid_drop", 32'(dmem_req_valid), 32'd0);
        check("to_stall", 32'(stall_mem), 32'd0);
        check("to_data", data_mem_out, 32'h0);
        @(negedge clk); #1;
        check("to_bus_err_pulse", 32'(bus_err), 32'd0);

        // Reset while REQ is outstanding drops valid immediately.
        load_txn("pre_rst", 32'h300, 3'b010, 32'h7777_1111, 4'hF, 32'h7777_1111);
        start("rst_req", 1'b1, 1'b0, 32'h300, 32'h0, 3'b010);
        @(negedge clk);
        rst_n = 1'b0;
        MemRd_MEM = 1'b0;
        #1;
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_req_stall", 32'(stall_mem), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during WAIT, then a late response in IDLE is ignored.
        start("rst_wait", 1'b1, 1'b0, 32'h300, 32'h0, 3'b010);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        check("rst_wait_stall_pre", 32'(stall_mem), 32'd1);
        rst_n = 1'b0;
        MemRd_MEM = 1'b0;
        #1;
        check("rst_wait_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_wait_stall", 32'(stall_mem), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hFEED_FACE;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        #1;
        check("late_rsp_data", data_mem_out, 32'h0);
        check("late_rsp_stall", 32'(stall_mem), 32'd0);
        check("late_rsp_valid", 32'(dmem_req_valid), 32'd0);

        // Misaligned LW @0x101.
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        load_txn("pre_mis", 32'h400, 3'b010, 32'h2468_ACE0, 4'hF, 32'h2468_ACE0);
        start("lw_mis", 1'b1, 1'b0, 32'h101, 32'h0, 3'b010);
        @(negedge clk);
        MemRd_MEM = 1'b0;
        #1;
        check("lw_mis_exc", 32'(misalign_exc), 32'd1);
        check("lw_mis_valid", 32'(dmem_req_valid), 32'd0);
        check("lw_mis_stall", 32'(stall_mem), 32'd0);
        check("lw_mis_data", data_mem_out, 32'h0);
        @(negedge clk); #1;
        check("lw_mis_exc_pulse", 32'(misalign_exc), 32'd0);
        check("lw_mis_valid_after", 32'(dmem_req_valid), 32'd0);
`else
        load_txn("lw_mis", 32'h101, 3'b010, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D);
        check("lw_mis_exc", 32'(misalign_exc), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
